line_encoder: RTL

//  Sequential 8-to-3 request encoder: the inverse of the RAM row decoder. Collects
//  per-line requests into a sticky pending set, picks one line (round-robin or fixed

---
 rtl/ram8_pkg.sv | 24 ++
 rtl/line_pick.sv | 51 +++++
 rtl/line_encoder.sv | 113 +++++++++++
 3 files changed

// File: rtl/ram8_pkg.sv
// Package: ram8_pkg
// Definitions shared by the RAM row decoder side and the line encoder side.
//   LINES   - number of word lines (fixed at 8)
//   CODE_W  - width of an encoded line index (3)
//   state_t - offer FSM states: IDLE (nothing offered), OFFER (code on the bus)
//   idx2code - maps a line index to the decoder bit order: code[2]=k[0],
//              code[1]=k[1], code[0]=k[2]. The mapping is its own inverse.
package ram8_pkg;

  localparam int LINES  = 8;
  localparam int CODE_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  // The row decoder wires its address bits in reversed order, so the encoder
  // emits the line index bit-reversed.
  function automatic logic [CODE_W-1:0] idx2code(input logic [CODE_W-1:0] idx);
    return {idx[0], idx[1], idx[2]};
  endfunction

endpackage

// File: rtl/line_pick.sv
// Module: line_pick
// Combinational rotate-priority picker over the 8 request lines.
// Ports:
//   cand    in  8  candidate lines (one bit per line)
//   ptr     in  3  round-robin start position
//   rr_mode in  1  1: search upward from ptr with wrap; 0: lowest index wins
//   found   out 1  at least one candidate bit is set
//   index   out 3  chosen line index (valid when found=1)
module line_pick
  import ram8_pkg::*;
(
  input  logic [LINES-1:0]  cand,
  input  logic [CODE_W-1:0] ptr,
  input  logic              rr_mode,
  output logic              found,
  output logic [CODE_W-1:0] index
);

  logic [CODE_W-1:0] base;
  logic [LINES-1:0]  rot;
  logic [CODE_W-1:0] offset;

  // Fixed-priority mode is just a rotation by zero.
  assign base = rr_mode ? ptr : '0;

  // Rotate the candidates so that position 0 of rot is the line at base; the
  // 3-bit index sum wraps 7->0 on its own.
  always_comb begin
    rot = '0;
    for (int i = 0; i < LINES; i++) begin
      rot[i] = cand[CODE_W'(i) + base];
    end
  end

  // Lowest set bit of the rotated vector wins; scanning downward lets the
  // lowest one overwrite any higher hit.
  always_comb begin
    found  = 1'b0;
    offset = '0;
    for (int i = LINES - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found  = 1'b1;
        offset = CODE_W'(i);
      end
    end
  end

  // Undo the rotation to get back to the absolute line number.
  assign index = offset + base;

endmodule

// File: rtl/line_encoder.sv
// Module: line_encoder
// Sequential 8-to-3 request encoder. Requests are collected into a sticky
// pending set, one line is picked (round-robin or fixed priority) and its
// bit-reversed code is offered on a valid/ready handshake.
// Parameters:
//   ROUND_ROBIN 1: rotating priority after last grant; 0: lowest index wins
// Ports:
//   clk     in   1  clock, all state on rising edge
//   rst_n   in   1  asynchronous reset, active low
//   req_i   in   8  per-line requests, OR'ed into the pending set every cycle
//   clr_i   in   1  synchronous clear of pending set and offer
//   code_o  out  3  offered line in decoder bit order
//   valid_o out  1  code_o holds an offered line
//   ready_i in   1  consumer accepts code_o when valid_o=1
//   pend_o  out  8  pending set register
//   ovf_o   out  1  one-cycle pulse: a request hit an already-pending line
module line_encoder
  import ram8_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LINES-1:0]  req_i,
  input  logic              clr_i,
  output logic [CODE_W-1:0] code_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [LINES-1:0]  pend_o,
  output logic              ovf_o
);

  state_t            state;
  logic [LINES-1:0]  pend;
  logic [CODE_W-1:0] sel_idx;
  logic [CODE_W-1:0] ptr;
  logic [LINES-1:0]  inflight;
  logic [LINES-1:0]  hs_mask;
  logic [LINES-1:0]  cand;
  logic              hs;
  logic              load;
  logic              pick_found;
  logic [CODE_W-1:0] pick_idx;

  // The offered line stays in pend until handshaked, so it is masked out of
  // selection while on the bus; that way a reload on handshake never re-picks it.
  assign inflight = (state == OFFER) ? ({{(LINES-1){1'b0}}, 1'b1} << sel_idx) : '0;
  assign hs       = (state == OFFER) && ready_i;
  assign hs_mask  = hs ? inflight : '0;
  assign cand     = pend & ~inflight;
  assign load     = (state == IDLE) || hs;
  assign pend_o   = pend;

  line_pick u_pick (
    .cand    (cand),
    .ptr     (ptr),
    .rr_mode (ROUND_ROBIN),
    .found   (pick_found),
    .index   (pick_idx)
  );

  // Pending set: retire the handshaked line, then merge new requests, so a
  // request for the line being accepted right now keeps it pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else if (clr_i) begin
      pend <= '0;
    end else begin
      pend <= (pend & ~hs_mask) | req_i;
    end
  end

  // Overflow pulse: a request landed on a line that was already pending and
  // is not being retired this cycle. A clear discards the requests, so nothing
  // merges and no pulse is raised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_o <= 1'b0;
    end else begin
      ovf_o <= !clr_i && (|(req_i & pend & ~hs_mask));
    end
  end

  // Offer FSM with registered outputs. A new line is loaded whenever the bus
  // is free (IDLE) or is being freed by a handshake; with nothing to offer we
  // fall back to IDLE. The round-robin pointer moves past each loaded line,
  // and a clear leaves it where it is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      valid_o <= 1'b0;
      code_o  <= '0;
      sel_idx <= '0;
      ptr     <= '0;
    end else if (clr_i) begin
      state   <= IDLE;
      valid_o <= 1'b0;
    end else if (load) begin
      if (pick_found) begin
        state   <= OFFER;
        valid_o <= 1'b1;
        sel_idx <= pick_idx;
        code_o  <= idx2code(pick_idx);
        ptr     <= pick_idx + CODE_W'(1);
      end else begin
        state   <= IDLE;
        valid_o <= 1'b0;
      end
    end
  end

endmodule
